// File: rtl/ad5445_pkg.sv
// Shared AD5445 bus constants, timing defaults and readback FSM states.
package ad5445_pkg;

  localparam int unsigned DAC_DW       = 12;
  localparam int unsigned ERR_W        = 16;

  // Bus timing defaults shared by the reader and the writer.
  localparam int unsigned T_TURN_DEF   = 2;
  localparam int unsigned T_ACC_DEF    = 4;
  localparam int unsigned T_REC_DEF    = 3;
  localparam int unsigned AUTO_PER_DEF = 100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_TURN,
    ST_ACC,
    ST_REC
  } rb_state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ad5445_readback_if.sv
// DAC pin bundle plus the bus_req/bus_gnt handshake with the board-level mux.
interface ad5445_readback_if;
  import ad5445_pkg::*;

  logic              bus_req;
  logic              bus_gnt;
  logic              dac_rw_ctr;
  logic              dac_cs_n;
  logic              dac_d_oe;
  logic [DAC_DW-1:0] dac_d_in;

  modport master (
    output bus_req, dac_rw_ctr, dac_cs_n, dac_d_oe,
    input  bus_gnt, dac_d_in
  );

  modport slave (
    input  bus_req, dac_rw_ctr, dac_cs_n, dac_d_oe,
    output bus_gnt, dac_d_in
  );

endinterface

// File: rtl/ad5445_tick_gen.sv
// Free-running period counter: one-cycle tick each PER cycles while en is high.
module ad5445_tick_gen
  import ad5445_pkg::*;
#(
  parameter int unsigned PER = AUTO_PER_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = cnt_width(PER);

  logic [CW-1:0] cnt;

  // Count 0..PER-1, flag the wrap; disabling restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(PER - 1));
      cnt  <= (cnt == CW'(PER - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ad5445_readback.sv
// AD5445 readback engine: arbitrates for the DAC pins, reads the input
// register, compares it with the expected code and counts mismatches.
module ad5445_readback
  import ad5445_pkg::*;
#(
  parameter int unsigned DW       = DAC_DW,
  parameter int unsigned T_TURN   = T_TURN_DEF,
  parameter int unsigned T_ACC    = T_ACC_DEF,
  parameter int unsigned T_REC    = T_REC_DEF,
  parameter int unsigned AUTO_PER = AUTO_PER_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_req,
  input  logic                auto_en,
  input  logic [DW-1:0]       rd_expect,
  input  logic                err_clr,
  ad5445_readback_if.master   dac,
  output logic                rd_busy,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic                rd_mismatch,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int unsigned T_MAX = (T_TURN > T_ACC) ?
                                  ((T_TURN > T_REC) ? T_TURN : T_REC) :
                                  ((T_ACC  > T_REC) ? T_ACC  : T_REC);
  localparam int unsigned PH_W  = cnt_width(T_MAX);

  rb_state_e       state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            pending_q, pending_d;
  logic            bus_req_q, bus_req_d;
  logic            cs_n_q, cs_n_d;
  logic            valid_d, mism_d;
  logic [DW-1:0]   data_d;
  logic            auto_tick;

  ad5445_tick_gen #(.PER(AUTO_PER)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (auto_en),
    .tick (auto_tick)
  );

  // The reader never drives data and only ever issues reads.
  assign dac.bus_req    = bus_req_q;
  assign dac.dac_cs_n   = cs_n_q;
  assign dac.dac_rw_ctr = 1'b1;
  assign dac.dac_d_oe   = 1'b0;

  // State, phase and registered outputs; reset forces cs_n high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      pending_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_busy     <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      rd_mismatch <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      bus_req_q   <= bus_req_d;
      cs_n_q      <= cs_n_d;
      rd_busy     <= (state_d != ST_IDLE);
      rd_data     <= data_d;
      rd_valid    <= valid_d;
      rd_mismatch <= mism_d;
    end
  end

  // Next-state and next-output decode; values are for the state being entered.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    bus_req_d = bus_req_q;
    cs_n_d    = 1'b1;
    valid_d   = 1'b0;
    mism_d    = rd_mismatch;
    data_d    = rd_data;

    // A wrap while a request is already pending collapses into it.
    if (auto_tick) pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_req || pending_q) begin
          state_d   = ST_REQ;
          bus_req_d = 1'b1;
          pending_d = 1'b0;
        end
      end
      ST_REQ: begin
        bus_req_d = 1'b1;
        if (dac.bus_gnt) begin
          state_d = ST_TURN;
          phase_d = '0;
        end
      end
      ST_TURN: begin
        if (phase_q == PH_W'(T_TURN - 1)) begin
          state_d = ST_ACC;
          phase_d = '0;
          cs_n_d  = 1'b0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_ACC: begin
        cs_n_d = 1'b0;
        if (phase_q == PH_W'(T_ACC - 1)) begin
          state_d = ST_REC;
          phase_d = '0;
          cs_n_d  = 1'b1;
          data_d  = DW'(dac.dac_d_in);
          valid_d = 1'b1;
          mism_d  = (DW'(dac.dac_d_in) != rd_expect);
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_REC: begin
        if (phase_q == PH_W'(T_REC - 1)) begin
          state_d   = ST_IDLE;
          phase_d   = '0;
          bus_req_d = 1'b0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        phase_d   = '0;
        bus_req_d = 1'b0;
      end
    endcase

    if (!auto_en) pending_d = 1'b0;
  end

  // Saturating mismatch counter; a clear beats a simultaneous mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (rd_valid && rd_mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ad5445_readback.sv
// Directed bench for ad5445_readback with a scoreboard of expected readbacks.
module tb_ad5445_readback;
  import ad5445_pkg::*;

  typedef struct packed {
    logic [DAC_DW-1:0] code;
    logic              mis;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_req = 1'b0;
  logic              auto_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [DAC_DW-1:0] rd_expect = '0;
  logic              rd_busy;
  logic [DAC_DW-1:0] rd_data;
  logic              rd_valid;
  logic              rd_mismatch;
  logic [ERR_W-1:0]  err_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   valid_cnt = 0;

  ad5445_readback_if bus();

  ad5445_readback #(.AUTO_PER(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .auto_en    (auto_en),
    .rd_expect  (rd_expect),
    .err_clr    (err_clr),
    .dac        (bus),
    .rd_busy    (rd_busy),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_mismatch(rd_mismatch),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Independent tally of rd_valid pulses.
  always @(negedge clk) if (rd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DAC_DW-1:0] d, input logic [DAC_DW-1:0] e);
    exp_t x;
    bus.dac_d_in = d;
    rd_expect    = e;
    x.code = d;
    x.mis  = (d != e);
    sb.push_back(x);
  endtask

  task automatic start_read(input string tag);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    chk({tag, "_bus_req_rise"}, 32'(bus.bus_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget, input bit clr,
                            output int cyc, output int low);
    exp_t e;
    bit   seen = 1'b0;
    cyc = 0;
    low = 0;
    while (!seen && cyc < budget) begin
      step(1);
      cyc++;
      if (bus.dac_cs_n === 1'b0) low++;
      if (rd_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      if (clr) err_clr = 1'b1;
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_data"}, 32'(rd_data), 32'(e.code));
        chk({tag, "_mismatch"}, 32'(rd_mismatch), 32'(e.mis));
      end
      if (clr) begin
        step(1);
        err_clr = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (rd_busy === 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    if (rd_busy !== 1'b0) chk({tag, "_idle_timeout"}, 32'(rd_busy), 32'd0);
  endtask

  initial begin
    int cyc, low, rec, n, vc, breq_bad;

    bus.bus_gnt  = 1'b0;
    bus.dac_d_in = '0;

    // Reset state and quiet idle
    step(3);
    chk("rst_cs_n", 32'(bus.dac_cs_n), 32'd1);
    chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
    rst_n = 1'b1;
    step(20);
    chk("idle_cs_n", 32'(bus.dac_cs_n), 32'd1);
    chk("idle_rw", 32'(bus.dac_rw_ctr), 32'd1);
    chk("idle_bus_req", 32'(bus.bus_req), 32'd0);
    chk("idle_d_oe", 32'(bus.dac_d_oe), 32'd0);
    chk("idle_busy", 32'(rd_busy), 32'd0);
    chk("idle_rd_data", 32'(rd_data), 32'd0);
    chk("idle_err_cnt", 32'(err_cnt), 32'd0);
    chk("idle_no_valid", 32'(valid_cnt), 32'd0);

    // Single matching read with grant tied high
    bus.bus_gnt = 1'b1;
    push(12'hA5C, 12'hA5C);
    start_read("t2");
    wait_valid("t2", 30, 1'b0, cyc, low);
    chk("t2_latency", 32'(cyc), 32'd7);
    chk("t2_cs_low_width", 32'(low), 32'd4);
    wait_idle("t2", rec);
    chk("t2_rec_len", 32'(rec), 32'd3);
    chk("t2_bus_req_drop", 32'(bus.bus_req), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // Repeated mismatches, then a clear colliding with a mismatch
    for (int i = 0; i < 3; i++) begin
      push(12'h0FF, 12'h100);
      start_read("t3");
      wait_valid("t3", 30, 1'b0, cyc, low);
      wait_idle("t3", rec);
      chk("t3_err_cnt", 32'(err_cnt), 32'(i + 1));
    end
    push(12'h0FF, 12'h100);
    start_read("t3c");
    wait_valid("t3c", 30, 1'b1, cyc, low);
    wait_idle("t3c", rec);
    chk("t3_err_clr_wins", 32'(err_cnt), 32'd0);

    // Grant withheld for 50 cycles, extra request while busy is dropped
    bus.bus_gnt = 1'b0;
    push(12'h3C3, 12'h3C3);
    start_read("t4");
    low = 0;
    breq_bad = 0;
    for (int i = 0; i < 50; i++) begin
      rd_req = (i == 20);
      step(1);
      if (bus.dac_cs_n !== 1'b1) low++;
      if (bus.bus_req !== 1'b1) breq_bad++;
    end
    rd_req = 1'b0;
    chk("t4_cs_held_high", 32'(low), 32'd0);
    chk("t4_bus_req_held", 32'(breq_bad), 32'd0);
    chk("t4_busy_waiting", 32'(rd_busy), 32'd1);
    vc = valid_cnt;
    bus.bus_gnt = 1'b1;
    wait_valid("t4", 30, 1'b0, cyc, low);
    chk("t4_latency_from_gnt", 32'(cyc), 32'd7);
    wait_idle("t4", rec);
    step(30);
    chk("t4_single_valid", 32'(valid_cnt - vc), 32'd1);

    // Periodic auto readback, then disabled
    auto_en = 1'b1;
    push(12'h123, 12'h123);
    wait_valid("t5a", 200, 1'b0, cyc, low);
    push(12'h123, 12'h123);
    wait_valid("t5b", 100, 1'b0, cyc, low);
    chk("t5_period1", 32'(cyc), 32'd50);
    push(12'h123, 12'h123);
    wait_valid("t5c", 100, 1'b0, cyc, low);
    chk("t5_period2", 32'(cyc), 32'd50);
    auto_en = 1'b0;
    wait_idle("t5", rec);
    step(1);
    vc = valid_cnt;
    step(150);
    chk("t5_stopped", 32'(valid_cnt - vc), 32'd0);

    // Reset in the middle of the access phase
    bus.dac_d_in = 12'h555;
    rd_expect    = 12'hAAA;
    start_read("t6");
    n = 0;
    while (bus.dac_cs_n !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("t6_reached_acc", 32'(bus.dac_cs_n), 32'd0);
    step(1);
    vc = valid_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_async_cs_n", 32'(bus.dac_cs_n), 32'd1);
    chk("t6_async_bus_req", 32'(bus.bus_req), 32'd0);
    chk("t6_async_busy", 32'(rd_busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("t6_no_valid", 32'(valid_cnt - vc), 32'd0);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_cs_n_idle", 32'(bus.dac_cs_n), 32'd1);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
